// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: turns a resolved taken branch into a PC-load
// handshake plus a bounded IF/ID and ID/EX flush window, and counts accepted redirects.
module branch_redirect_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              brTaken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  input  logic              pc_ready,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              redirect_busy,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0]       FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
  localparam logic             MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        flush_cnt_r;
  logic [3:0]        flush_cnt_s;
  logic [ADDR_W-1:0] addr_s;
  logic [CNT_W-1:0]  count_s;

  // Next-state, flush-window counter, target latch and saturating branch count
  always_comb begin
    state_s     = state_r;
    flush_cnt_s = flush_cnt_r;
    addr_s      = pc_load_addr;
    count_s     = taken_count;
    case (state_r)
      ST_IDLE: begin
        if (brTaken && !stall) begin
          state_s = ST_REDIRECT;
          addr_s  = br_target;
          if (taken_count != CNT_MAX) begin
            count_s = taken_count + CNT_ONE;
          end else begin
            count_s = taken_count;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        // pc_load_addr stays untouched here so the fetch side sees a stable request
        if (pc_load && pc_ready) begin
          if (MULTI_FLUSH) begin
            state_s     = ST_FLUSH;
            flush_cnt_s = FLUSH_LOAD;
          end else begin
            state_s     = ST_IDLE;
            flush_cnt_s = 4'd0;
          end
        end else begin
          state_s = ST_REDIRECT;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r <= 4'd1) begin
          state_s     = ST_IDLE;
          flush_cnt_s = 4'd0;
        end else begin
          state_s     = ST_FLUSH;
          flush_cnt_s = flush_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        flush_cnt_s = 4'd0;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they rise on the same edge that samples brTaken
  always_ff @(posedge clk) begin
    if (!rest) begin
      state_r       <= ST_IDLE;
      flush_cnt_r   <= 4'd0;
      pc_load       <= 1'b0;
      pc_load_addr  <= '0;
      flush_ifid    <= 1'b0;
      flush_idex    <= 1'b0;
      redirect_busy <= 1'b0;
      taken_count   <= '0;
    end else begin
      state_r       <= state_s;
      flush_cnt_r   <= flush_cnt_s;
      pc_load       <= (state_s == ST_REDIRECT);
      pc_load_addr  <= addr_s;
      flush_ifid    <= (state_s != ST_IDLE);
      flush_idex    <= (state_s != ST_IDLE);
      redirect_busy <= (state_s != ST_IDLE);
      taken_count   <= count_s;
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl: a default instance,
// a CNT_W=2 instance for saturation and a FLUSH_CYCLES=1 instance for the short window.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rest;
  logic        brTaken;
  logic [15:0] br_target;
  logic        stall;
  logic        pc_ready;

  logic        pc_load, flush_ifid, flush_idex, redirect_busy;
  logic [15:0] pc_load_addr;
  logic [7:0]  taken_count;

  logic        s_pc_load, s_flush_ifid, s_flush_idex, s_busy;
  logic [15:0] s_addr;
  logic [1:0]  s_count;

  logic        f_pc_load, f_flush_ifid, f_flush_idex, f_busy;
  logic [15:0] f_addr;
  logic [7:0]  f_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .rest(rest), .brTaken(brTaken), .br_target(br_target), .stall(stall),
    .pc_ready(pc_ready), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .redirect_busy(redirect_busy),
    .taken_count(taken_count));

  branch_redirect_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rest(rest), .brTaken(brTaken), .br_target(br_target), .stall(stall),
    .pc_ready(pc_ready), .pc_load(s_pc_load), .pc_load_addr(s_addr),
    .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .redirect_busy(s_busy),
    .taken_count(s_count));

  branch_redirect_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(1), .CNT_W(8)) dut_f1 (
    .clk(clk), .rest(rest), .brTaken(brTaken), .br_target(br_target), .stall(stall),
    .pc_ready(pc_ready), .pc_load(f_pc_load), .pc_load_addr(f_addr),
    .flush_ifid(f_flush_ifid), .flush_idex(f_flush_idex), .redirect_busy(f_busy),
    .taken_count(f_count));

  // {pc_load, flush_ifid, flush_idex, redirect_busy} of the default instance
  function automatic logic [3:0] ctl();
    return {pc_load, flush_ifid, flush_idex, redirect_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rest = 1'b0; brTaken = 1'b1; br_target = 16'h1234; stall = 1'b0; pc_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b0000, 16'h0000, 8'd0}) begin
      n_fail++; $display("FAIL reset_main: got ctl=%b addr=%h cnt=%0d, want 0000/0000/0", ctl(), pc_load_addr, taken_count);
    end
    n_checks++;
    if ({s_pc_load, s_busy, s_count, f_pc_load, f_busy, f_count} !== 13'd0) begin
      n_fail++; $display("FAIL reset_others: sat pc_load=%b busy=%b cnt=%0d f1 pc_load=%b busy=%b cnt=%0d, want all 0",
                         s_pc_load, s_busy, s_count, f_pc_load, f_busy, f_count);
    end
    rest = 1'b1; brTaken = 1'b0;
    tick();
    n_checks++;
    if (ctl() !== 4'b0000) begin
      n_fail++; $display("FAIL reset_release_idle: got ctl=%b, want 0000", ctl());
    end
  endtask

  task automatic test_basic();
    brTaken = 1'b1; br_target = 16'h0040; pc_ready = 1'b1;
    tick();
    brTaken = 1'b0;
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b1111, 16'h0040, 8'd1}) begin
      n_fail++; $display("FAIL basic_redirect: got ctl=%b addr=%h cnt=%0d, want 1111/0040/1", ctl(), pc_load_addr, taken_count);
    end
    n_checks++;
    if ({f_pc_load, f_flush_ifid, f_flush_idex, f_busy, f_addr, f_count} !== {4'b1111, 16'h0040, 8'd1}) begin
      n_fail++; $display("FAIL basic_f1_redirect: got ctl=%b%b%b%b addr=%h cnt=%0d, want 1111/0040/1",
                         f_pc_load, f_flush_ifid, f_flush_idex, f_busy, f_addr, f_count);
    end
    tick();
    n_checks++;
    if ({ctl(), pc_load_addr} !== {4'b0111, 16'h0040}) begin
      n_fail++; $display("FAIL basic_flush: got ctl=%b addr=%h, want 0111/0040", ctl(), pc_load_addr);
    end
    n_checks++;
    if ({f_pc_load, f_flush_ifid, f_flush_idex, f_busy, f_addr} !== {4'b0000, 16'h0040}) begin
      n_fail++; $display("FAIL basic_f1_idle: got ctl=%b%b%b%b addr=%h, want 0000/0040",
                         f_pc_load, f_flush_ifid, f_flush_idex, f_busy, f_addr);
    end
    tick();
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b0000, 16'h0040, 8'd1}) begin
      n_fail++; $display("FAIL basic_idle: got ctl=%b addr=%h cnt=%0d, want 0000/0040/1", ctl(), pc_load_addr, taken_count);
    end
  endtask

  task automatic test_backpressure();
    brTaken = 1'b1; br_target = 16'h0040; pc_ready = 1'b0;
    tick();
    br_target = 16'h0099;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ctl(), pc_load_addr, taken_count} !== {4'b1111, 16'h0040, 8'd2}) begin
        n_fail++; $display("FAIL backpressure_hold[%0d]: got ctl=%b addr=%h cnt=%0d, want 1111/0040/2",
                           i, ctl(), pc_load_addr, taken_count);
      end
      if (i < 2) tick();
    end
    pc_ready = 1'b1; brTaken = 1'b0;
    tick();
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b0111, 16'h0040, 8'd2}) begin
      n_fail++; $display("FAIL backpressure_flush: got ctl=%b addr=%h cnt=%0d, want 0111/0040/2", ctl(), pc_load_addr, taken_count);
    end
    tick();
    n_checks++;
    if (ctl() !== 4'b0000) begin
      n_fail++; $display("FAIL backpressure_idle: got ctl=%b, want 0000", ctl());
    end
  endtask

  task automatic test_stall();
    brTaken = 1'b1; br_target = 16'h0123; stall = 1'b1;
    tick();
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b0000, 16'h0040, 8'd2}) begin
      n_fail++; $display("FAIL stall_ignored: got ctl=%b addr=%h cnt=%0d, want 0000/0040/2", ctl(), pc_load_addr, taken_count);
    end
    stall = 1'b0;
    tick();
    brTaken = 1'b0; stall = 1'b1;
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b1111, 16'h0123, 8'd3}) begin
      n_fail++; $display("FAIL stall_released: got ctl=%b addr=%h cnt=%0d, want 1111/0123/3", ctl(), pc_load_addr, taken_count);
    end
    tick();
    stall = 1'b0;
    n_checks++;
    if (ctl() !== 4'b0111) begin
      n_fail++; $display("FAIL stall_outside_idle: got ctl=%b, want 0111", ctl());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    brTaken = 1'b1; br_target = 16'h0200;
    tick();
    brTaken = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({ctl(), pc_load_addr} !== {4'b0000, 16'h0200}) begin
      n_fail++; $display("FAIL b2b_first_idle: got ctl=%b addr=%h, want 0000/0200", ctl(), pc_load_addr);
    end
    brTaken = 1'b1; br_target = 16'h0300;
    tick();
    brTaken = 1'b0;
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b1111, 16'h0300, 8'd5}) begin
      n_fail++; $display("FAIL b2b_second: got ctl=%b addr=%h cnt=%0d, want 1111/0300/5", ctl(), pc_load_addr, taken_count);
    end
    tick();
    tick();
  endtask

  task automatic test_saturation();
    n_checks++;
    if (s_count !== 2'd3) begin
      n_fail++; $display("FAIL sat_after_5: got %0d, want 3", s_count);
    end
    brTaken = 1'b1; br_target = 16'h0400;
    tick();
    brTaken = 1'b0;
    n_checks++;
    if ({s_count, taken_count, s_pc_load} !== {2'd3, 8'd6, 1'b1}) begin
      n_fail++; $display("FAIL sat_no_wrap: got sat=%0d main=%0d sat_pc_load=%b, want 3/6/1", s_count, taken_count, s_pc_load);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid_flush();
    brTaken = 1'b1; br_target = 16'h0500;
    tick();
    brTaken = 1'b0;
    tick();
    n_checks++;
    if (ctl() !== 4'b0111) begin
      n_fail++; $display("FAIL midflush_in_flush: got ctl=%b, want 0111", ctl());
    end
    rest = 1'b0;
    tick();
    n_checks++;
    if ({ctl(), pc_load_addr, taken_count} !== {4'b0000, 16'h0000, 8'd0}) begin
      n_fail++; $display("FAIL midflush_reset: got ctl=%b addr=%h cnt=%0d, want 0000/0000/0", ctl(), pc_load_addr, taken_count);
    end
    rest = 1'b1;
    tick();
    // reset while stuck in REDIRECT must drop pc_load without it reappearing
    brTaken = 1'b1; br_target = 16'h0600; pc_ready = 1'b0;
    tick();
    brTaken = 1'b0;
    rest = 1'b0;
    tick();
    rest = 1'b1;
    tick();
    n_checks++;
    if ({ctl(), taken_count} !== {4'b0000, 8'd0}) begin
      n_fail++; $display("FAIL midredirect_reset: got ctl=%b cnt=%0d, want 0000/0", ctl(), taken_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
